// File: rtl/itcm_boot_loader_pkg.sv
// Shared types for the ITCM boot loader: FSM state encoding, default frame magic and state-class helpers.
package itcm_boot_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam logic [BYTE_W-1:0] BOOT_MAGIC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    BOOT_ST_IDLE   = 3'd0,
    BOOT_ST_LEN_HI = 3'd1,
    BOOT_ST_LEN_LO = 3'd2,
    BOOT_ST_DATA   = 3'd3,
    BOOT_ST_CSUM   = 3'd4,
    BOOT_ST_DONE   = 3'd5,
    BOOT_ST_ERR    = 3'd6
  } boot_state_e;

  // States in which the loader is willing to take bytes.
  function automatic logic is_rx_state(boot_state_e s);
    return (s == BOOT_ST_IDLE) || (s == BOOT_ST_LEN_HI) || (s == BOOT_ST_LEN_LO) ||
           (s == BOOT_ST_DATA) || (s == BOOT_ST_CSUM);
  endfunction

  // States inside a frame, where the inter-byte timeout applies.
  function automatic logic is_frame_state(boot_state_e s);
    return (s == BOOT_ST_LEN_HI) || (s == BOOT_ST_LEN_LO) ||
           (s == BOOT_ST_DATA) || (s == BOOT_ST_CSUM);
  endfunction

endpackage

// File: rtl/itcm_boot_loader_word_packer.sv
// Packs MSB-first bytes into 32-bit words; word_ready_c/word_c are valid in the cycle the 4th byte is offered.
module itcm_boot_loader_word_packer
  import itcm_boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_ready_c,
  output logic [WORD_W-1:0] word_c
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  assign word_ready_c = byte_en && (cnt_q == 2'd3);
  assign word_c       = {shift_q, byte_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_en) begin
      shift_q <= {shift_q[15:0], byte_data};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/itcm_boot_loader.sv
// Loads a framed byte stream into instruction memory and holds the core in reset until done.
// Optional trailing checksum byte enabled by defining BOOT_CHECKSUM_EN.
module itcm_boot_loader
  import itcm_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter logic [7:0]  MAGIC       = BOOT_MAGIC_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  localparam int unsigned IDX_W     = ADDR_W + 1;
  localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  boot_state_e      state_q, state_d;
  logic             ready_q, ready_d;
  logic [7:0]       len_hi_q;
  logic [IDX_W-1:0] len_q, len_d, idx_q;
  logic [TMO_W-1:0] tmo_q;
  logic [7:0]       sum_q;
  logic             accept_c, pack_en_c, pack_clr_c, word_ready_c, last_word_c, timeout_c;
  logic [31:0]      word_c;
  logic [15:0]      len_word_c;

  // restart masks the handshake combinationally so a simultaneous byte is never taken
  assign in_ready    = ready_q & ~restart;
  assign accept_c    = in_valid & in_ready;
  assign pack_en_c   = accept_c && (state_q == BOOT_ST_DATA);
  assign pack_clr_c  = restart || (state_q == BOOT_ST_IDLE);
  assign len_word_c  = {len_hi_q, in_data};
  assign last_word_c = word_ready_c && ((idx_q + IDX_W'(1)) == len_q);
  assign timeout_c   = is_frame_state(state_q) && !accept_c &&
                       (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  itcm_boot_loader_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear        (pack_clr_c),
    .byte_en      (pack_en_c),
    .byte_data    (in_data),
    .word_ready_c (word_ready_c),
    .word_c       (word_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT_ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (restart) begin
      state_d = BOOT_ST_IDLE;
    end else if (timeout_c) begin
      state_d = BOOT_ST_ERR;
    end else begin
      case (state_q)
        BOOT_ST_IDLE:   if (accept_c && (in_data == MAGIC)) state_d = BOOT_ST_LEN_HI;
        BOOT_ST_LEN_HI: if (accept_c) state_d = BOOT_ST_LEN_LO;
        BOOT_ST_LEN_LO: begin
          if (accept_c) begin
            len_d = IDX_W'(len_word_c);
            if (len_word_c == 16'd0)               state_d = CSUM_EN ? BOOT_ST_CSUM : BOOT_ST_DONE;
            else if (32'(len_word_c) > MAX_WORDS) state_d = BOOT_ST_ERR;
            else                                  state_d = BOOT_ST_DATA;
          end
        end
        BOOT_ST_DATA: begin
          // without a checksum, DONE follows the final write strobe by one cycle
          if (CSUM_EN) begin
            if (last_word_c) state_d = BOOT_ST_CSUM;
          end else if (idx_q == len_q) begin
            state_d = BOOT_ST_DONE;
          end
        end
        BOOT_ST_CSUM: begin
          if (accept_c) state_d = (8'(sum_q + in_data) == 8'h00) ? BOOT_ST_DONE : BOOT_ST_ERR;
        end
        default: ;
      endcase
    end
    ready_d = is_rx_state(state_d) && !(last_word_c && !CSUM_EN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_rst  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ready_q  <= ready_d;
      mem_we   <= word_ready_c;
      if (word_ready_c) begin
        mem_addr  <= idx_q[ADDR_W-1:0];
        mem_wdata <= word_c;
      end
      core_rst <= (state_d != BOOT_ST_DONE);
      done     <= (state_d == BOOT_ST_DONE);
      err      <= (state_d == BOOT_ST_ERR);
    end
  end

  // Frame length, write index, inter-byte timeout and running checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      tmo_q    <= '0;
      sum_q    <= '0;
    end else begin
      len_q <= len_d;
      if (accept_c && (state_q == BOOT_ST_LEN_HI)) len_hi_q <= in_data;
      if (pack_clr_c)        idx_q <= '0;
      else if (word_ready_c) idx_q <= idx_q + IDX_W'(1);
      if (accept_c || !is_frame_state(state_q)) tmo_q <= '0;
      else                                      tmo_q <= tmo_q + TMO_W'(1);
      if (state_q == BOOT_ST_IDLE) sum_q <= '0;
      else if (accept_c)           sum_q <= 8'(sum_q + in_data);
    end
  end

endmodule

// File: tb/tb_itcm_boot_loader.sv
// Directed bench for itcm_boot_loader: cycle table for the main frame plus timeout, length, checksum and reset sequences.
module tb_itcm_boot_loader;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned TMO    = 40;

  logic clk = 1'b0;
  logic rst, restart, in_valid, in_ready, mem_we, core_rst, done, err;
  logic [7:0] in_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0] fr[$];

  typedef struct packed {
    logic v; logic [7:0] d; logic rs;
    logic we; logic [ADDR_W-1:0] addr; logic [31:0] wd;
    logic dn; logic er; logic crst; logic rdy;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  itcm_boot_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .done(done), .err(err)
  );

  always @(negedge clk) begin
    if (!rst && mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic v, input logic [7:0] d, input logic rs, input logic we,
                              input logic [ADDR_W-1:0] a, input logic [31:0] wd, input logic dn,
                              input logic er, input logic crst, input logic rdy);
    vec_t r;
    r.v = v; r.d = d; r.rs = rs; r.we = we; r.addr = a; r.wd = wd;
    r.dn = dn; r.er = er; r.crst = crst; r.rdy = rdy;
    tbl.push_back(r);
  endfunction

  function automatic logic [7:0] csum_of();
    logic [7:0] s = 8'h00;
    for (int i = 1; i < fr.size(); i++) s = 8'(s + fr[i]);
    return 8'(8'h00 - s);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("ready_wait", 32'(in_ready), 32'(1));
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stop_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < fr.size(); i++) send_byte(fr[i]);
`ifdef BOOT_CHECKSUM_EN
    send_byte(csum_of());
`endif
    stop_in();
  endtask

  task automatic do_restart();
    @(negedge clk);
    in_valid = 1'b0;
    restart  = 1'b1;
    @(negedge clk);
    restart  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(done), 32'(1));
  endtask

  initial begin
    rst = 1'b1; restart = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'(0));
    check("rst_we", 32'(mem_we), 32'(0));
    check("rst_addr", 32'(mem_addr), 32'(0));
    check("rst_wdata", mem_wdata, 32'(0));
    check("rst_core_rst", 32'(core_rst), 32'(1));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // frame A5 00 02 | 24010005 | 3C021234, then junk + empty frame, then restart racing a byte
    add(1, 8'hA5, 0, 0, 4'd0, 32'h0,        0, 0, 1, 1);
    add(1, 8'h00, 0, 0, 4'd0, 32'h0,        0, 0, 1, 1);
    add(1, 8'h02, 0, 0, 4'd0, 32'h0,        0, 0, 1, 1);
    add(1, 8'h24, 0, 0, 4'd0, 32'h0,        0, 0, 1, 1);
    add(1, 8'h01, 0, 0, 4'd0, 32'h0,        0, 0, 1, 1);
    add(1, 8'h00, 0, 0, 4'd0, 32'h0,        0, 0, 1, 1);
    add(1, 8'h05, 0, 1, 4'd0, 32'h24010005, 0, 0, 1, 1);
    add(1, 8'h3C, 0, 0, 4'd0, 32'h24010005, 0, 0, 1, 1);
    add(1, 8'h02, 0, 0, 4'd0, 32'h24010005, 0, 0, 1, 1);
    add(1, 8'h12, 0, 0, 4'd0, 32'h24010005, 0, 0, 1, 1);
`ifdef BOOT_CHECKSUM_EN
    add(1, 8'h34, 0, 1, 4'd1, 32'h3C021234, 0, 0, 1, 1);
    add(1, 8'h50, 0, 0, 4'd1, 32'h3C021234, 1, 0, 0, 0);
`else
    add(1, 8'h34, 0, 1, 4'd1, 32'h3C021234, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 4'd1, 32'h3C021234, 1, 0, 0, 0);
`endif
    add(0, 8'h00, 0, 0, 4'd1, 32'h3C021234, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 4'd1, 32'h3C021234, 0, 0, 1, 0);
    add(1, 8'h00, 0, 0, 4'd1, 32'h3C021234, 0, 0, 1, 1);
    add(1, 8'hFF, 0, 0, 4'd1, 32'h3C021234, 0, 0, 1, 1);
    add(1, 8'hA5, 0, 0, 4'd1, 32'h3C021234, 0, 0, 1, 1);
    add(1, 8'h00, 0, 0, 4'd1, 32'h3C021234, 0, 0, 1, 1);
`ifdef BOOT_CHECKSUM_EN
    add(1, 8'h00, 0, 0, 4'd1, 32'h3C021234, 0, 0, 1, 1);
    add(1, 8'h00, 0, 0, 4'd1, 32'h3C021234, 1, 0, 0, 0);
`else
    add(1, 8'h00, 0, 0, 4'd1, 32'h3C021234, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 4'd1, 32'h3C021234, 1, 0, 0, 0);
`endif
    add(1, 8'hA5, 1, 0, 4'd1, 32'h3C021234, 0, 0, 1, 0);
    add(1, 8'h00, 0, 0, 4'd1, 32'h3C021234, 0, 0, 1, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      in_valid = tbl[i].v; in_data = tbl[i].d; restart = tbl[i].rs;
      @(posedge clk);
      #1;
      check($sformatf("row%0d_we", i), 32'(mem_we), 32'(tbl[i].we));
      check($sformatf("row%0d_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
      check($sformatf("row%0d_wdata", i), mem_wdata, tbl[i].wd);
      check($sformatf("row%0d_done", i), 32'(done), 32'(tbl[i].dn));
      check($sformatf("row%0d_err", i), 32'(err), 32'(tbl[i].er));
      check($sformatf("row%0d_core_rst", i), 32'(core_rst), 32'(tbl[i].crst));
      check($sformatf("row%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
    end
    @(negedge clk);
    in_valid = 1'b0; restart = 1'b0;

    // inter-byte timeout mid-word, then recovery with a full frame
    do_restart();
    wr_addr.delete(); wr_data.delete();
    fr = '{8'hA5, 8'h00, 8'h01, 8'h24, 8'h01};
    for (int i = 0; i < fr.size(); i++) send_byte(fr[i]);
    stop_in();
    repeat (TMO - 1) @(negedge clk);
    check("tmo_err_before", 32'(err), 32'(0));
    @(negedge clk);
    check("tmo_err", 32'(err), 32'(1));
    check("tmo_core_rst", 32'(core_rst), 32'(1));
    check("tmo_ready", 32'(in_ready), 32'(0));
    check("tmo_no_we", 32'(wr_addr.size()), 32'(0));
    do_restart();
    check("restart_err_clr", 32'(err), 32'(0));
    fr = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame();
    wait_done("reload_done");
    check("reload_cnt", 32'(wr_addr.size()), 32'(1));
    if (wr_addr.size() == 1) begin
      check("reload_addr", 32'(wr_addr[0]), 32'(0));
      check("reload_data", wr_data[0], 32'hDEADBEEF);
    end
    check("reload_core_rst", 32'(core_rst), 32'(0));

    // length over capacity (17 > 16) errors at LEN_LO accept
    do_restart();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h11);
    check("len_err", 32'(err), 32'(1));
    check("len_err_core_rst", 32'(core_rst), 32'(1));
    stop_in();

    // exactly capacity: 16 words, last written at address 15
    do_restart();
    wr_addr.delete(); wr_data.delete();
    fr = '{8'hA5, 8'h00, 8'h10};
    for (int i = 0; i < 64; i++) fr.push_back(8'(i));
    send_frame();
    wait_done("full_done");
    check("full_cnt", 32'(wr_addr.size()), 32'(16));
    for (int w = 0; w < 16 && w < wr_addr.size(); w++) begin
      check($sformatf("full_addr%0d", w), 32'(wr_addr[w]), 32'(w));
      check($sformatf("full_data%0d", w), wr_data[w],
            {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)});
    end

`ifdef BOOT_CHECKSUM_EN
    // corrupted checksum byte
    do_restart();
    fr = '{8'hA5, 8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'h3C, 8'h02, 8'h12, 8'h34};
    for (int i = 0; i < fr.size(); i++) send_byte(fr[i]);
    send_byte(8'(csum_of() + 8'h01));
    check("csum_bad_err", 32'(err), 32'(1));
    check("csum_bad_core_rst", 32'(core_rst), 32'(1));
    check("csum_bad_done", 32'(done), 32'(0));
    stop_in();
`endif

    // async reset in the middle of word 1
    do_restart();
    wr_addr.delete(); wr_data.delete();
    fr = '{8'hA5, 8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'h3C, 8'h02};
    for (int i = 0; i < fr.size(); i++) send_byte(fr[i]);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_ready", 32'(in_ready), 32'(0));
    check("arst_we", 32'(mem_we), 32'(0));
    check("arst_addr", 32'(mem_addr), 32'(0));
    check("arst_wdata", mem_wdata, 32'(0));
    check("arst_core_rst", 32'(core_rst), 32'(1));
    check("arst_done", 32'(done), 32'(0));
    check("arst_err", 32'(err), 32'(0));
    check("arst_writes", 32'(wr_addr.size()), 32'(1));
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
